// File: rtl/dcpu2.sv
// dcpu2: parametrised two-stack CPU core with a wait-state tolerant cs/we/ack bus,
// carry flag and sticky stack error flags. Define DCPU2_IRQ_EN for interrupt entry/return.
module dcpu2 #(
  parameter int unsigned   W        = 16,
  parameter int unsigned   DSS      = 5,
  parameter int unsigned   RSS      = 5,
  parameter logic [W-1:0]  RESET_PC = '0,
  parameter logic [W-1:0]  IRQ_VEC  = W'(16'h0008)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic [W-1:0] o_addr,
  output logic [W-1:0] o_dat,
  input  logic [W-1:0] i_dat,
  input  logic         i_ack,
  output logic         o_we,
  output logic         o_cs,
  input  logic         i_irq,
  output logic [3:0]   o_stk_err
);

  localparam int unsigned DD = 2**DSS;
  localparam int unsigned RD = 2**RSS;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_IRQ} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d, op_q;
  logic [DSS-1:0] dsp_q, dsp_d;
  logic [RSS-1:0] rsp_q, rsp_d;
  logic [DSS:0]   dd_q, dd_d;
  logic [RSS:0]   rd_q, rd_d;
  logic           carry_q, carry_d;
  logic [3:0]     err_q, err_d;
`ifdef DCPU2_IRQ_EN
  logic           ie_q, ie_d;
`else
  logic           unused_irq;
  assign unused_irq = ^{i_irq, IRQ_VEC};
`endif

  logic [W-1:0]   dstk [DD];
  logic [W-1:0]   rstk [RD];
  logic           dwe, rwe;
  logic [DSS-1:0] dwa;
  logic [W-1:0]   dwd, rwd;

  logic         is_lit, is_wr, is_mem, commit_c, upd_c;
  logic         dpush, dpop, rpush, rpop;
  logic [2:0]   dst;
  logic [4:0]   alu;
  logic [1:0]   dspc, rspc;
  logic [W-1:0] t_w, n_w, r_w, mem_addr;
  logic [W:0]   res;

  assign is_lit = ~op_q[W-1];
  assign dst    = op_q[14:12];
  assign alu    = op_q[11:7];
  assign dspc   = op_q[6:5];
  assign rspc   = op_q[4:3];
  assign is_wr  = !is_lit && (dst[2:1] == 2'b10);
  assign is_mem = is_wr || (!is_lit && (alu == 5'h0c || alu == 5'h0d));

  assign t_w = dstk[dsp_q];
  assign n_w = dstk[dsp_q - DSS'(1)];
  assign r_w = rstk[rsp_q];

  // Write address follows dst; otherwise the load opcode picks T or R.
  assign mem_addr = (is_wr ? (dst == 3'b100) : (alu == 5'h0c)) ? t_w : r_w;

  assign commit_c = (state_q == S_EXEC && !is_mem) || (state_q == S_MEM && i_ack);
  assign upd_c    = commit_c || (state_q == S_IRQ);

  always_comb begin
    res = {1'b0, t_w};
    case (alu)
      5'h01: res = {1'b0, n_w};
      5'h02: res = {1'b0, r_w};
      5'h03: res = {1'b0, n_w} + {1'b0, t_w};
      5'h04: res = {1'b0, n_w} - {1'b0, t_w};
      5'h05: res = {1'b0, n_w & t_w};
      5'h06: res = {1'b0, n_w | t_w};
      5'h07: res = {1'b0, n_w ^ t_w};
      5'h08: res = {1'b0, {W{n_w == t_w}}};
      5'h09: res = {1'b0, ~t_w};
      5'h0a: res = {2'b00, t_w[W-1:1]};
      5'h0b: res = {t_w, 1'b0};
      5'h0c, 5'h0d: res = is_wr ? {1'b0, t_w} : {1'b0, i_dat};
      5'h0e: res = {1'b0, (t_w == '0) ? r_w : pc_q};
      5'h0f: res = {1'b0, (t_w == '0) ? n_w : pc_q};
      5'h10: res = (W+1)'(t_w) + (W+1)'(1);
      5'h11: res = (W+1)'(t_w) - (W+1)'(1);
      5'h12: res = (W+1)'(carry_q);
      default: res = {1'b0, t_w};
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dsp_d   = dsp_q;
    rsp_d   = rsp_q;
    dd_d    = dd_q;
    rd_d    = rd_q;
    carry_d = carry_q;
    err_d   = err_q;
    dpush   = 1'b0;
    dpop    = 1'b0;
    rpush   = 1'b0;
    rpop    = 1'b0;
    dwe     = 1'b0;
    dwa     = dsp_q;
    dwd     = res[W-1:0];
    rwe     = 1'b0;
    rwd     = res[W-1:0];
`ifdef DCPU2_IRQ_EN
    ie_d    = ie_q;
`endif
    if (commit_c) begin
      state_d = S_FETCH;
      dpush   = is_lit || dspc == 2'b01;
      dpop    = !is_lit && dspc == 2'b10;
      rpush   = !is_lit && rspc[0];
      rpop    = !is_lit && rspc == 2'b10;
    end
`ifdef DCPU2_IRQ_EN
    if (state_q == S_IRQ) rpush = 1'b1;
`endif
    // Pointers wrap; depth saturates and errors stick.
    if (dpush) begin
      dsp_d = dsp_q + DSS'(1);
      if (dd_q == (DSS+1)'(DD)) err_d[0] = 1'b1;
      else dd_d = dd_q + (DSS+1)'(1);
    end else if (dpop) begin
      dsp_d = dsp_q - DSS'(1);
      if (dd_q == '0) err_d[1] = 1'b1;
      else dd_d = dd_q - (DSS+1)'(1);
    end
    if (rpush) begin
      rsp_d = rsp_q + RSS'(1);
      if (rd_q == (RSS+1)'(RD)) err_d[2] = 1'b1;
      else rd_d = rd_q + (RSS+1)'(1);
    end else if (rpop) begin
      rsp_d = rsp_q - RSS'(1);
      if (rd_q == '0) err_d[3] = 1'b1;
      else rd_d = rd_q - (RSS+1)'(1);
    end
    if (commit_c) begin
      dwe = is_lit || dst[2:1] == 2'b00;
      dwa = (!is_lit && dst == 3'b001) ? dsp_d - DSS'(1) : dsp_d;
      dwd = is_lit ? {1'b0, op_q[W-2:0]} : res[W-1:0];
      if (!is_lit) begin
        if (rspc == 2'b11) begin
          rwe = 1'b1;
          rwd = pc_q;
        end else if (dst == 3'b010) begin
          rwe = 1'b1;
        end
        if (dst == 3'b011) pc_d = res[W-1:0];
        if (alu == 5'h03 || alu == 5'h04 || alu == 5'h0b) carry_d = res[W];
      end
`ifdef DCPU2_IRQ_EN
      if (!is_lit && op_q[0]) ie_d = 1'b1;
      else if (i_irq && ie_q) state_d = S_IRQ;
`endif
    end
`ifdef DCPU2_IRQ_EN
    if (state_q == S_IRQ) begin
      rwe     = 1'b1;
      rwd     = pc_q;
      pc_d    = IRQ_VEC;
      ie_d    = 1'b0;
      state_d = S_FETCH;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (dwe) dstk[dwa] <= dwd;
    if (rwe) rstk[rsp_d] <= rwd;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      op_q    <= '0;
      dsp_q   <= '0;
      rsp_q   <= '0;
      dd_q    <= '0;
      rd_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= '0;
`ifdef DCPU2_IRQ_EN
      ie_q    <= 1'b0;
`endif
    end else begin
      if (state_q == S_FETCH && i_ack) begin
        op_q    <= i_dat;
        pc_q    <= pc_q + W'(1);
        state_q <= S_EXEC;
      end else if (state_q == S_EXEC && is_mem) begin
        state_q <= S_MEM;
      end else if (upd_c) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        dsp_q   <= dsp_d;
        rsp_q   <= rsp_d;
        dd_q    <= dd_d;
        rd_q    <= rd_d;
        carry_q <= carry_d;
        err_q   <= err_d;
`ifdef DCPU2_IRQ_EN
        ie_q    <= ie_d;
`endif
      end
    end
  end

  // Bus outputs are decoded from state; reset drops the request immediately.
  assign o_cs      = !i_reset && (state_q == S_FETCH || state_q == S_MEM);
  assign o_we      = o_cs && state_q == S_MEM && is_wr;
  assign o_addr    = !o_cs ? '0 : (state_q == S_FETCH ? pc_q : mem_addr);
  assign o_dat     = o_we ? res[W-1:0] : '0;
  assign o_stk_err = err_q;

endmodule

// File: tb/tb_dcpu2.sv
// Self-checking bench for dcpu2: bus transactions are compared against a scoreboard queue.
module tb_dcpu2;

  logic        i_clk, i_reset, i_ack, i_irq, o_we, o_cs;
  logic [15:0] o_addr, o_dat, i_dat;
  logic [3:0]  o_stk_err;

  typedef struct packed {logic [15:0] a; logic we; logic [15:0] d;} txn_t;
  txn_t        exp_q[$];
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  dcpu2 dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_addr(o_addr), .o_dat(o_dat), .i_dat(i_dat),
    .i_ack(i_ack), .o_we(o_we), .o_cs(o_cs), .i_irq(i_irq), .o_stk_err(o_stk_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] nop(input logic [2:0] dst, input logic [4:0] alu,
                                      input logic [1:0] dsp, input logic [1:0] rsp,
                                      input logic flag);
    return {1'b1, dst, alu, dsp, rsp, 2'b00, flag};
  endfunction

  task automatic push_rd(input logic [15:0] a);
    exp_q.push_back({a, 1'b0, 16'h0000});
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, 1'b1, d});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_ack   = 1'b0;
    i_irq   = 1'b0;
    i_dat   = 16'h0000;
    exp_q.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // Serve one bus transaction with dly wait states, checking it against the scoreboard.
  task automatic bus_txn(input int dly);
    txn_t        e;
    int          waitc;
    logic [15:0] a, d;
    logic        we;
    waitc = 0;
    while (o_cs !== 1'b1 && waitc < 20) begin
      @(negedge i_clk);
      waitc++;
    end
    checks++;
    if (o_cs !== 1'b1) begin
      errors++;
      $display("FAIL bus_timeout: o_cs=%b required 1", o_cs);
      return;
    end
    a = o_addr; we = o_we; d = o_dat;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bus_extra: addr=%h we=%b dat=%h required no transaction", a, we, d);
    end else begin
      e = exp_q.pop_front();
      if ({a, we, d} !== e)begin
        errors++;
        $display("FAIL bus_txn: addr=%h we=%b dat=%h required addr=%h we=%b dat=%h",
                 a, we, d, e.a, e.we, e.d);
      end
    end
    for (int i = 0; i < dly; i++) begin
      i_ack = 1'b0;
      @(negedge i_clk);
      checks++;
      if (o_cs !== 1'b1 || o_addr !== a || o_we !== we || o_dat !== d) begin
        errors++;
        $display("FAIL bus_hold: cs=%b addr=%h we=%b dat=%h required cs=1 addr=%h we=%b dat=%h",
                 o_cs, o_addr, o_we, o_dat, a, we, d);
      end
    end
    i_ack = 1'b1;
    i_dat = we ? 16'h0000 : mem[a[7:0]];
    if (we) mem[a[7:0]] = d;
    @(negedge i_clk);
    i_ack = 1'b0;
    i_dat = 16'h0000;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d pending required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_ack = 1'b0; i_irq = 1'b0; i_dat = 16'h0000;
    #1;
    checks++;
    if (o_cs !== 1'b0) begin errors++; $display("FAIL reset_cs_held: %b required 0", o_cs); end
    do_reset();
    #1;
    checks++;
    if ({o_cs, o_we, o_addr, o_dat, o_stk_err} !== {1'b1, 1'b0, 16'h0, 16'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: cs=%b we=%b addr=%h dat=%h err=%h required 1 0 0000 0000 0",
               o_cs, o_we, o_addr, o_dat, o_stk_err);
    end
  endtask

  task automatic test_alu();
    clear_mem(); do_reset();
    mem[0] = 16'h0005; mem[1] = 16'h0003; mem[2] = nop(3'b000, 5'h03, 2'b10, 2'b00, 1'b0);
    mem[3] = nop(3'b100, 5'h00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) push_rd(16'(i));
    push_wr(16'h0008, 16'h0008);
    for (int i = 0; i < 5; i++) bus_txn(0);
    checks++;
    if (dut.dsp_q !== 5'd1 || dut.carry_q !== 1'b0) begin
      errors++; $display("FAIL add_state: dsp=%0d carry=%b required 1 0", dut.dsp_q, dut.carry_q);
    end
    check_drained("add");

    clear_mem(); do_reset();
    mem[0] = 16'h4000; mem[1] = nop(3'b000, 5'h0b, 2'b00, 2'b00, 1'b0);
    mem[2] = mem[1];   mem[3] = nop(3'b000, 5'h12, 2'b01, 2'b00, 1'b0);
    mem[4] = nop(3'b100, 5'h00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) push_rd(16'(i));
    push_wr(16'h0001, 16'h0001);
    for (int i = 0; i < 4; i++) bus_txn(0);
    checks++;
    if (dut.carry_q !== 1'b1) begin
      errors++; $display("FAIL shl_carry: %b required 1", dut.carry_q);
    end
    for (int i = 0; i < 2; i++) bus_txn(0);
    check_drained("shl");

    clear_mem(); do_reset();
    mem[0] = 16'h0003; mem[1] = 16'h0005; mem[2] = nop(3'b000, 5'h04, 2'b10, 2'b00, 1'b0);
    mem[3] = nop(3'b100, 5'h00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) push_rd(16'(i));
    push_wr(16'hFFFE, 16'hFFFE);
    for (int i = 0; i < 5; i++) bus_txn(0);
    checks++;
    if (dut.carry_q !== 1'b1) begin
      errors++; $display("FAIL sub_borrow: %b required 1", dut.carry_q);
    end
    check_drained("sub");
  endtask

  task automatic test_mem();
    clear_mem(); do_reset();
    mem[0] = 16'h1234; mem[1] = 16'h0100; mem[2] = nop(3'b100, 5'h01, 2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) push_rd(16'(i));
    push_wr(16'h0100, 16'h1234);
    push_rd(16'h0003);
    for (int i = 0; i < 3; i++) bus_txn(0);
    bus_txn(3);
    bus_txn(0);
    checks++;
    if (mem[8'h00] !== 16'h1234 || dut.dsp_q !== 5'd1) begin
      errors++; $display("FAIL write_result: mem=%h dsp=%0d required 1234 1", mem[8'h00], dut.dsp_q);
    end
    check_drained("write");

    clear_mem(); do_reset();
    mem[8'h30] = 16'hBEEF; mem[0] = 16'h0030; mem[1] = nop(3'b000, 5'h0c, 2'b00, 2'b00, 1'b0);
    mem[2] = nop(3'b100, 5'h00, 2'b00, 2'b00, 1'b0);
    push_rd(16'h0000); push_rd(16'h0001); push_rd(16'h0030); push_rd(16'h0002);
    push_wr(16'hBEEF, 16'hBEEF);
    bus_txn(0); bus_txn(0); bus_txn(2); bus_txn(0); bus_txn(0);
    check_drained("read");
  endtask

  task automatic test_call_return();
    clear_mem(); do_reset();
    mem[0] = 16'h0040; mem[1] = 16'h0010; mem[2] = nop(3'b011, 5'h00, 2'b10, 2'b00, 1'b0);
    mem[8'h10] = nop(3'b011, 5'h00, 2'b00, 2'b11, 1'b0);
    mem[8'h40] = nop(3'b100, 5'h02, 2'b00, 2'b00, 1'b0);
    mem[8'h41] = nop(3'b011, 5'h02, 2'b00, 2'b10, 1'b0);
    push_rd(16'h0000); push_rd(16'h0001); push_rd(16'h0002); push_rd(16'h0010);
    push_rd(16'h0040); push_wr(16'h0040, 16'h0011); push_rd(16'h0041); push_rd(16'h0011);
    for (int i = 0; i < 8; i++) bus_txn(0);
    checks++;
    if (dut.rsp_q !== 5'd0 || o_stk_err !== 4'h0) begin
      errors++; $display("FAIL return_rsp: rsp=%0d err=%h required 0 0", dut.rsp_q, o_stk_err);
    end
    check_drained("call");
  endtask

  task automatic test_stack_err();
    clear_mem(); do_reset();
    for (int i = 0; i < 33; i++) begin
      mem[i] = 16'(i);
      push_rd(16'(i));
    end
    for (int i = 0; i < 32; i++) bus_txn(0);
    @(negedge i_clk);
    checks++;
    if (o_stk_err !== 4'b0000) begin
      errors++; $display("FAIL push32_err: %b required 0000", o_stk_err);
    end
    bus_txn(0);
    @(negedge i_clk);
    checks++;
    if (o_stk_err !== 4'b0001) begin
      errors++; $display("FAIL push33_err: %b required 0001", o_stk_err);
    end
    check_drained("push");
    do_reset();
    #1;
    checks++;
    if (o_stk_err !== 4'b0000) begin
      errors++; $display("FAIL err_reset: %b required 0000", o_stk_err);
    end
    clear_mem();
    mem[0] = nop(3'b110, 5'h00, 2'b00, 2'b10, 1'b0);
    mem[1] = nop(3'b110, 5'h00, 2'b10, 2'b00, 1'b0);
    push_rd(16'h0000); push_rd(16'h0001);
    bus_txn(0);
    @(negedge i_clk);
    checks++;
    if (o_stk_err !== 4'b1000) begin
      errors++; $display("FAIL rpop_empty: %b required 1000", o_stk_err);
    end
    bus_txn(0);
    @(negedge i_clk);
    checks++;
    if (o_stk_err !== 4'b1010) begin
      errors++; $display("FAIL dpop_empty: %b required 1010", o_stk_err);
    end
    check_drained("pop");
  endtask

  task automatic test_reset_in_mem();
    clear_mem(); do_reset();
    mem[0] = 16'h0050; mem[1] = nop(3'b100, 5'h00, 2'b00, 2'b00, 1'b0);
    push_rd(16'h0000); push_rd(16'h0001);
    bus_txn(0); bus_txn(0);
    @(negedge i_clk);
    checks++;
    if (o_cs !== 1'b1 || o_we !== 1'b1 || o_addr !== 16'h0050) begin
      errors++; $display("FAIL mem_wait: cs=%b we=%b addr=%h required 1 1 0050", o_cs, o_we, o_addr);
    end
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_cs !== 1'b0) begin errors++; $display("FAIL reset_drop_cs: %b required 0", o_cs); end
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_cs !== 1'b1 || o_addr !== 16'h0000) begin
      errors++; $display("FAIL restart_fetch: cs=%b addr=%h required 1 0000", o_cs, o_addr);
    end
    push_rd(16'h0000);
    bus_txn(0);
    check_drained("rstmem");
  endtask

`ifdef DCPU2_IRQ_EN
  task automatic test_irq();
    clear_mem(); do_reset();
    mem[0] = 16'h0020; mem[1] = nop(3'b011, 5'h00, 2'b10, 2'b00, 1'b1);
    mem[8'h20] = 16'h0007; mem[8'h08] = nop(3'b100, 5'h02, 2'b00, 2'b00, 1'b0);
    push_rd(16'h0000); push_rd(16'h0001); push_rd(16'h0020); push_rd(16'h0008);
    push_wr(16'h0007, 16'h0021);
    bus_txn(0); bus_txn(0); bus_txn(0);
    checks++;
    if (dut.ie_q !== 1'b1) begin errors++; $display("FAIL ie_set: %b required 1", dut.ie_q); end
    i_irq = 1'b1;
    bus_txn(0);
    i_irq = 1'b0;
    checks++;
    if (dut.ie_q !== 1'b0) begin errors++; $display("FAIL ie_clear: %b required 0", dut.ie_q); end
    bus_txn(0);
    check_drained("irq");
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_call_return();
    test_stack_err();
    test_reset_in_mem();
`ifdef DCPU2_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
